// File: rtl/cordic_iter_scheduler.sv
// Iterative CORDIC rotator shared by NREQ requesters through a round-robin arbiter.
// Ports: per-requester valid/ready + packed x/y/phase in; tagged result out over valid/ready; busy.
module cordic_iter_scheduler #(
    parameter int WW      = 16,
    parameter int PW      = 20,
    parameter int NSTAGES = 14,
    parameter int NREQ    = 2,
    parameter int IDW     = (NREQ > 2) ? $clog2(NREQ) : 1
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    input  logic [NREQ-1:0]    i_req_valid,
    output logic [NREQ-1:0]    o_req_ready,
    input  logic [NREQ*WW-1:0] i_req_x,
    input  logic [NREQ*WW-1:0] i_req_y,
    input  logic [NREQ*PW-1:0] i_req_phase,
    output logic               o_res_valid,
    input  logic               i_res_ready,
    output logic [WW-1:0]      o_res_x,
    output logic [WW-1:0]      o_res_y,
    output logic [PW-1:0]      o_res_phase,
    output logic [IDW-1:0]     o_res_id,
    output logic               o_busy
);
    localparam int KW = (NSTAGES > 2) ? $clog2(NSTAGES) : 1;

    typedef enum logic [1:0] {IDLE, ROTATE, DONE} state_t;
    state_t state, state_nxt;

    // atan(2^-(k+1)) scaled so that a full turn is 2^PW, rounded to nearest
    function automatic logic [PW-1:0] atan_entry(input int k);
        real a;
        a = $atan(1.0 / (2.0 ** (k + 1))) / (2.0 * 3.14159265358979323846)
            * (2.0 ** PW);
        return PW'($rtoi(a + 0.5));
    endfunction

    logic [PW-1:0] atab [NSTAGES];
    for (genvar g = 0; g < NSTAGES; g++) begin : g_atan
        localparam logic [PW-1:0] AV = atan_entry(g);
        assign atab[g] = AV;
    end

    logic signed [WW-1:0] rx [NREQ];
    logic signed [WW-1:0] ry [NREQ];
    logic [PW-1:0]        rp [NREQ];
    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign rx[g] = i_req_x[g*WW +: WW];
        assign ry[g] = i_req_y[g*WW +: WW];
        assign rp[g] = i_req_phase[g*PW +: PW];
    end

    logic [IDW-1:0]       rr, id, gnt, cand;
    logic [KW-1:0]        k;
    logic signed [WW-1:0] x, y, xs, ys, x_nxt, y_nxt;
    logic [PW-1:0]        phase, ang, ph_nxt;
    logic [KW:0]          sh;
    logic                 found, pass, last;
    logic [WW-1:0]        res_x, res_y;
    logic [PW-1:0]        res_phase;
    logic [IDW-1:0]       res_id;

    // Round-robin search starting at rr, wrapping at NREQ
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        cand  = rr;
        for (int i = 0; i < NREQ; i++) begin
            if (!found && i_req_valid[cand]) begin
                found = 1'b1;
                gnt   = cand;
            end
            cand = (cand == IDW'(NREQ - 1)) ? '0 : cand + 1'b1;
        end
    end

    // One micro-rotation; iterations whose angle rounds to 0 or whose shift
    // clears the word are skipped so x/y/phase hold
    always_comb begin
        sh     = {1'b0, k} + 1'b1;
        ang    = atab[k];
        pass   = (ang == '0) || (int'(sh) >= WW);
        xs     = x >>> sh;
        ys     = y >>> sh;
        x_nxt  = x;
        y_nxt  = y;
        ph_nxt = phase;
        if (!pass) begin
            if (phase[PW-1]) begin
                x_nxt  = x + ys;
                y_nxt  = y - xs;
                ph_nxt = phase + ang;
            end else begin
                x_nxt  = x - ys;
                y_nxt  = y + xs;
                ph_nxt = phase - ang;
            end
        end
    end

    assign last = (k == KW'(NSTAGES - 1));

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) state <= IDLE;
        else            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (found)       state_nxt = ROTATE;
            ROTATE:  if (last)        state_nxt = DONE;
            DONE:    if (i_res_ready) state_nxt = IDLE;
            default:                  state_nxt = IDLE;
        endcase
    end

    always_comb begin
        o_req_ready = '0;
        if (state == IDLE && found) o_req_ready[gnt] = 1'b1;
        o_res_valid = (state == DONE);
        o_busy      = (state == ROTATE) || (state == DONE);
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            rr        <= '0;
            id        <= '0;
            k         <= '0;
            x         <= '0;
            y         <= '0;
            phase     <= '0;
            res_x     <= '0;
            res_y     <= '0;
            res_phase <= '0;
            res_id    <= '0;
        end else if (state == IDLE && found) begin
            x     <= rx[gnt];
            y     <= ry[gnt];
            phase <= rp[gnt];
            id    <= gnt;
            k     <= '0;
            rr    <= (gnt == IDW'(NREQ - 1)) ? '0 : gnt + 1'b1;
        end else if (state == ROTATE) begin
            x     <= x_nxt;
            y     <= y_nxt;
            phase <= ph_nxt;
            // Result registers only change here, so they hold through IDLE
            if (last) begin
                res_x     <= x_nxt;
                res_y     <= y_nxt;
                res_phase <= ph_nxt;
                res_id    <= id;
            end else begin
                k <= k + 1'b1;
            end
        end
    end

    assign o_res_x     = res_x;
    assign o_res_y     = res_y;
    assign o_res_phase = res_phase;
    assign o_res_id    = res_id;

endmodule

// File: tb/tb_cordic_iter_scheduler.sv
// Self-checking bench for cordic_iter_scheduler: scoreboard of modelled results,
// per-scenario tasks for reset, arbitration, latency, backpressure, mid-job reset, random.
module tb_cordic_iter_scheduler;
    localparam int  WW      = 16;
    localparam int  PW      = 20;
    localparam int  NSTAGES = 14;
    localparam int  NREQ    = 2;
    localparam int  IDW     = 1;
    localparam real PI      = 3.14159265358979323846;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [NREQ-1:0]    req_valid = '0;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*WW-1:0] req_x = '0;
    logic [NREQ*WW-1:0] req_y = '0;
    logic [NREQ*PW-1:0] req_phase = '0;
    logic               res_valid;
    logic               res_ready = 1'b0;
    logic [WW-1:0]      res_x, res_y;
    logic [PW-1:0]      res_phase;
    logic [IDW-1:0]     res_id;
    logic               busy;

    always #5 clk = ~clk;

    cordic_iter_scheduler #(
        .WW(WW), .PW(PW), .NSTAGES(NSTAGES), .NREQ(NREQ), .IDW(IDW)
    ) dut (
        .i_clk(clk),
        .i_reset_n(rst_n),
        .i_req_valid(req_valid),
        .o_req_ready(req_ready),
        .i_req_x(req_x),
        .i_req_y(req_y),
        .i_req_phase(req_phase),
        .o_res_valid(res_valid),
        .i_res_ready(res_ready),
        .o_res_x(res_x),
        .o_res_y(res_y),
        .o_res_phase(res_phase),
        .o_res_id(res_id),
        .o_busy(busy)
    );

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [WW-1:0]  x;
        logic [WW-1:0]  y;
        logic [PW-1:0]  ph;
    } res_t;

    res_t            sb[$];
    logic [PW-1:0]   atab [NSTAGES];
    int              checks = 0;
    int              errors = 0;
    int              cyc = 0;
    bit              acc, pop;
    int              acc_id;
    int              obs_cyc;
    logic            obs_busy, obs_valid;
    logic [NREQ-1:0] obs_ready;
    res_t            obs_res;

    function automatic res_t model(input logic [IDW-1:0] id,
                                   input logic signed [WW-1:0] x0,
                                   input logic signed [WW-1:0] y0,
                                   input logic [PW-1:0] p0);
        logic signed [WW-1:0] x, y, xn, yn;
        logic [PW-1:0]        p;
        res_t                 r;
        x = x0;
        y = y0;
        p = p0;
        for (int k = 0; k < NSTAGES; k++) begin
            if (atab[k] != '0 && k + 1 < WW) begin
                if (p[PW-1]) begin
                    xn = x + (y >>> (k + 1));
                    yn = y - (x >>> (k + 1));
                    p  = p + atab[k];
                end else begin
                    xn = x - (y >>> (k + 1));
                    yn = y + (x >>> (k + 1));
                    p  = p - atab[k];
                end
                x = xn;
                y = yn;
            end
        end
        r.id = id;
        r.x  = x;
        r.y  = y;
        r.ph = p;
        return r;
    endfunction

    task automatic set_req(input int r, input logic [WW-1:0] x,
                           input logic [WW-1:0] y, input logic [PW-1:0] p);
        req_x[r*WW +: WW]     = x;
        req_y[r*WW +: WW]     = y;
        req_phase[r*PW +: PW] = p;
        req_valid[r]          = 1'b1;
    endtask

    // Called at a negedge with inputs set; observes, scores accepts, returns at next negedge
    task automatic run_cycle();
        #1;
        acc       = 1'b0;
        obs_cyc   = cyc;
        obs_busy  = busy;
        obs_ready = req_ready;
        obs_valid = res_valid;
        obs_res.id = res_id;
        obs_res.x  = res_x;
        obs_res.y  = res_y;
        obs_res.ph = res_phase;
        for (int r = 0; r < NREQ; r++) begin
            if (req_valid[r] && req_ready[r]) begin
                acc    = 1'b1;
                acc_id = r;
                sb.push_back(model(IDW'(r), req_x[r*WW +: WW],
                                   req_y[r*WW +: WW], req_phase[r*PW +: PW]));
            end
        end
        pop = obs_valid && res_ready;
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        run_cycle();
        #1;
        checks++;
        if (res_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid got=%b exp=0", res_valid);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy got=%b exp=0", busy);
        end
        checks++;
        if (req_ready !== '0) begin
            errors++;
            $display("FAIL reset_ready got=%b exp=0", req_ready);
        end
        checks++;
        if ({res_id, res_x, res_y, res_phase} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got id=%0d x=%0d y=%0d ph=%0d exp=0",
                     res_id, res_x, res_y, res_phase);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_arbitration();
        int   ids[$];
        int   pop0 = -1, acc1 = -1;
        res_t e;
        set_req(0, WW'(1000), WW'(2000), PW'(5000));
        set_req(1, WW'(-3000), WW'(4000), PW'(-20000));
        res_ready = 1'b1;
        #1;
        checks++;
        if (req_ready !== 2'b01) begin
            errors++;
            $display("FAIL arb_first_ready got=%b exp=01", req_ready);
        end
        for (int n = 0; n < 100 && ids.size() < 2; n++) begin
            run_cycle();
            if (acc) begin
                req_valid[acc_id] = 1'b0;
                if (acc_id == 1) acc1 = obs_cyc;
            end
            if (pop) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL arb_result got unexpected id=%0d exp=none", obs_res.id);
                end else begin
                    e = sb.pop_front();
                    if (obs_res !== e) begin
                        errors++;
                        $display("FAIL arb_result got=%h exp=%h", obs_res, e);
                    end
                end
                if (ids.size() == 0) pop0 = obs_cyc;
                ids.push_back(int'(obs_res.id));
            end
        end
        checks++;
        if (ids.size() != 2 || ids[0] != 0 || ids[1] != 1) begin
            errors++;
            $display("FAIL arb_order got %0d results exp ids 0 then 1", ids.size());
        end
        checks++;
        if (acc1 != pop0 + 1) begin
            errors++;
            $display("FAIL arb_ch1_accept got cycle=%0d exp=%0d", acc1, pop0 + 1);
        end
    endtask

    task automatic test_single();
        bit   done = 1'b0;
        res_t e;
        int   gx, gy, gp;
        logic signed [PW-1:0] sp;
        set_req(0, WW'(16384), WW'(0), PW'(87381));
        res_ready = 1'b1;
        for (int n = 0; n < 60 && !done; n++) begin
            run_cycle();
            if (acc) req_valid[acc_id] = 1'b0;
            if (pop) begin
                done = 1'b1;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL t1_exact got unexpected result exp=none");
                end else begin
                    e = sb.pop_front();
                    if (obs_res !== e) begin
                        errors++;
                        $display("FAIL t1_exact got=%h exp=%h", obs_res, e);
                    end
                end
                gx = int'($signed(obs_res.x));
                gy = int'($signed(obs_res.y));
                sp = obs_res.ph;
                gp = int'(sp);
                checks++;
                if (obs_res.id !== 1'b0) begin
                    errors++;
                    $display("FAIL t1_id got=%0d exp=0", obs_res.id);
                end
                checks++;
                if (gx < 16521 - 8 || gx > 16521 + 8) begin
                    errors++;
                    $display("FAIL t1_x got=%0d exp=16521+/-8", gx);
                end
                checks++;
                if (gy < 9539 - 8 || gy > 9539 + 8) begin
                    errors++;
                    $display("FAIL t1_y got=%0d exp=9539+/-8", gy);
                end
                checks++;
                if (gp < -64 || gp > 64) begin
                    errors++;
                    $display("FAIL t1_phase got=%0d exp=|ph|<=64", gp);
                end
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL t1_timeout got no result exp=result within 60 cycles");
        end
    endtask

    task automatic test_latency();
        int   c0 = -1, fv = -1;
        res_t e;
        set_req(1, WW'(-12000), WW'(5000), PW'(-60000));
        res_ready = 1'b1;
        for (int n = 0; n < 60 && fv < 0; n++) begin
            run_cycle();
            if (acc) begin
                c0 = obs_cyc;
                req_valid[acc_id] = 1'b0;
                checks++;
                if (obs_busy !== 1'b0) begin
                    errors++;
                    $display("FAIL lat_busy_accept got=%b exp=0", obs_busy);
                end
            end else if (c0 >= 0) begin
                checks++;
                if (obs_busy !== 1'b1) begin
                    errors++;
                    $display("FAIL lat_busy cycle=%0d got=%b exp=1", obs_cyc - c0, obs_busy);
                end
            end
            if (pop) begin
                fv = obs_cyc;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL lat_result got unexpected result exp=none");
                end else begin
                    e = sb.pop_front();
                    if (obs_res !== e) begin
                        errors++;
                        $display("FAIL lat_result got=%h exp=%h", obs_res, e);
                    end
                end
            end
        end
        checks++;
        if (c0 < 0 || fv - c0 != NSTAGES + 1) begin
            errors++;
            $display("FAIL lat_first_valid got=%0d exp=%0d", fv - c0, NSTAGES + 1);
        end
        run_cycle();
        checks++;
        if (obs_busy !== 1'b0) begin
            errors++;
            $display("FAIL lat_busy_after_pop got=%b exp=0", obs_busy);
        end
    endtask

    task automatic test_backpressure();
        res_t held, e;
        int   got_n = 0;
        bit   seen = 1'b0;
        set_req(0, WW'(12000), WW'(-7000), PW'(30000));
        res_ready = 1'b0;
        for (int n = 0; n < 60 && !seen; n++) begin
            run_cycle();
            if (acc) begin
                req_valid[acc_id] = 1'b0;
                set_req(1, WW'(2500), WW'(-9000), PW'(100000));
            end
            if (obs_valid) begin
                seen = 1'b1;
                held = obs_res;
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL bp_timeout got no valid exp=valid within 60 cycles");
        end
        for (int n = 0; n < 5; n++) begin
            run_cycle();
            checks++;
            if (obs_valid !== 1'b1 || obs_res !== held) begin
                errors++;
                $display("FAIL bp_hold got v=%b %h exp v=1 %h", obs_valid, obs_res, held);
            end
            checks++;
            if (obs_ready !== '0) begin
                errors++;
                $display("FAIL bp_ready got=%b exp=0", obs_ready);
            end
        end
        res_ready = 1'b1;
        for (int n = 0; n < 60 && got_n < 2; n++) begin
            run_cycle();
            if (acc) req_valid[acc_id] = 1'b0;
            if (pop) begin
                got_n++;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL bp_result got unexpected result exp=none");
                end else begin
                    e = sb.pop_front();
                    if (obs_res !== e) begin
                        errors++;
                        $display("FAIL bp_result got=%h exp=%h", obs_res, e);
                    end
                end
            end
        end
        checks++;
        if (got_n != 2) begin
            errors++;
            $display("FAIL bp_count got=%0d exp=2", got_n);
        end
    endtask

    task automatic test_reset_mid();
        bit   ok = 1'b0;
        bit   done = 1'b0;
        res_t e;
        set_req(0, WW'(9000), WW'(3000), PW'(-40000));
        res_ready = 1'b1;
        for (int n = 0; n < 10 && !ok; n++) begin
            run_cycle();
            if (acc) begin
                ok = 1'b1;
                req_valid[acc_id] = 1'b0;
            end
        end
        repeat (7) run_cycle();
        checks++;
        if (!ok || obs_busy !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_inflight got busy=%b exp=1", obs_busy);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (res_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_ctrl got v=%b busy=%b exp=0,0", res_valid, busy);
        end
        checks++;
        if ({res_id, res_x, res_y, res_phase} !== '0) begin
            errors++;
            $display("FAIL rst_mid_outputs got x=%0d y=%0d ph=%0d exp=0",
                     res_x, res_y, res_phase);
        end
        sb.delete();
        repeat (2) run_cycle();
        rst_n = 1'b1;
        set_req(0, WW'(100), WW'(100), PW'(0));
        set_req(1, WW'(-8000), WW'(6000), PW'(50000));
        #1;
        checks++;
        if (req_ready !== 2'b01) begin
            errors++;
            $display("FAIL rst_mid_rr got=%b exp=01", req_ready);
        end
        req_valid[0] = 1'b0;
        for (int n = 0; n < 60 && !done; n++) begin
            run_cycle();
            if (acc) req_valid[acc_id] = 1'b0;
            if (pop) begin
                done = 1'b1;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL rst_mid_result got unexpected result exp=none");
                end else begin
                    e = sb.pop_front();
                    if (obs_res !== e || obs_res.id !== 1'b1) begin
                        errors++;
                        $display("FAIL rst_mid_result got=%h exp=%h", obs_res, e);
                    end
                end
            end
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL rst_mid_timeout got no result exp=result");
        end
    endtask

    task automatic test_random();
        int   pops = 0;
        int   n = 0;
        int   waitc [NREQ];
        res_t e;
        for (int r = 0; r < NREQ; r++) waitc[r] = 0;
        while (pops < 1000 && n < 60000) begin
            for (int r = 0; r < NREQ; r++) begin
                if (!req_valid[r] && $urandom_range(0, 1) == 1)
                    set_req(r, WW'($urandom), WW'($urandom),
                            PW'(int'($urandom_range(0, 300000)) - 150000));
            end
            res_ready = ($urandom_range(0, 3) != 0);
            run_cycle();
            n++;
            if (acc) begin
                for (int r = 0; r < NREQ; r++)
                    if (r != acc_id && req_valid[r]) waitc[r]++;
                waitc[acc_id] = 0;
                req_valid[acc_id] = 1'b0;
                for (int r = 0; r < NREQ; r++) begin
                    checks++;
                    if (waitc[r] > NREQ) begin
                        errors++;
                        $display("FAIL rnd_fair req=%0d got wait=%0d exp<=%0d", r, waitc[r], NREQ);
                    end
                end
            end
            if (pop) begin
                pops++;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL rnd_result got unexpected result exp=none");
                end else begin
                    e = sb.pop_front();
                    if (obs_res !== e) begin
                        errors++;
                        $display("FAIL rnd_result job=%0d got=%h exp=%h", pops, obs_res, e);
                    end
                end
            end
        end
        checks++;
        if (pops < 1000) begin
            errors++;
            $display("FAIL rnd_timeout got=%0d jobs exp=1000", pops);
        end
        req_valid = '0;
    endtask

    initial begin
        for (int k = 0; k < NSTAGES; k++)
            atab[k] = PW'($rtoi($atan(1.0 / (2.0 ** (k + 1))) / (2.0 * PI)
                               * (2.0 ** PW) + 0.5));
        test_reset();
        test_arbitration();
        test_single();
        test_latency();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
